// File: rtl/axo_bus_arbiter.sv
// axo_bus_arbiter: shares one downstream memory port between the instruction
// fetch port (prog_*) and the load/store port (mem_*). A grant is held until
// the transfer completes. Contending ports alternate. A watchdog latches a
// sticky fault if the downstream port stalls for too long.
module axo_bus_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    // instruction fetch port
    input  logic            prog_re,
    input  logic [XLEN-1:0] prog_addr,
    output logic            prog_ready,
    output logic [XLEN-1:0] prog_data,
    // load/store port
    input  logic            mem_re,
    input  logic            mem_we,
    input  logic [1:0]      mem_asize,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    output logic [XLEN-1:0] mem_rdata,
    output logic            mem_ready,
    // downstream memory port
    output logic            bus_re,
    output logic            bus_we,
    output logic [1:0]      bus_asize,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_ready,
    output logic            bus_fault
);

    localparam int unsigned    CNT_W       = 16;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic           WDOG_EN     = 1'(TIMEOUT != 0);
    localparam logic [1:0]     WORD_SIZE   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GNT_MEM  = 2'd1,
        ST_GNT_PROG = 2'd2,
        ST_FAULT    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             last_prog_q, last_prog_d;   // port served most recently was fetch
    logic             served_q, served_d;         // at least one transfer done since reset
    logic [CNT_W-1:0] wdog_q, wdog_d;

    logic mem_req_c;
    logic tie_to_mem_c;
    logic wdog_expired_c;

    assign mem_req_c      = mem_re | mem_we;
    // Before any transfer the data port wins a tie; afterwards the port not served last wins.
    assign tie_to_mem_c   = ~served_q | last_prog_q;
    assign wdog_expired_c = WDOG_EN & (wdog_q == TIMEOUT_CNT);

    // Read data is shared; each requester qualifies it with its own ready.
    assign prog_data = bus_rdata;
    assign mem_rdata = bus_rdata;

    // State, arbitration history and watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_prog_q <= 1'b0;
            served_q    <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            last_prog_q <= last_prog_d;
            served_q    <= served_d;
            wdog_q      <= wdog_d;
        end
    end

    // Next-state: arbitration, completion hand-over, request release and watchdog.
    always_comb begin
        state_d     = state_q;
        last_prog_d = last_prog_q;
        served_d    = served_q;
        wdog_d      = wdog_q;

        case (state_q)
            ST_IDLE: begin
                wdog_d = '0;
                if (mem_req_c && prog_re) begin
                    state_d = tie_to_mem_c ? ST_GNT_MEM : ST_GNT_PROG;
                end else if (mem_req_c) begin
                    state_d = ST_GNT_MEM;
                end else if (prog_re) begin
                    state_d = ST_GNT_PROG;
                end
            end

            ST_GNT_MEM: begin
                if (bus_ready) begin
                    // completing port counts as idle; hand straight to fetch if waiting
                    last_prog_d = 1'b0;
                    served_d    = 1'b1;
                    wdog_d      = '0;
                    state_d     = prog_re ? ST_GNT_PROG : ST_IDLE;
                end else if (wdog_expired_c) begin
                    state_d = ST_FAULT;
                end else if (!mem_req_c) begin
                    wdog_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + CNT_W'(1);
                end
            end

            ST_GNT_PROG: begin
                if (bus_ready) begin
                    last_prog_d = 1'b1;
                    served_d    = 1'b1;
                    wdog_d      = '0;
                    state_d     = mem_req_c ? ST_GNT_MEM : ST_IDLE;
                end else if (wdog_expired_c) begin
                    state_d = ST_FAULT;
                end else if (!prog_re) begin
                    wdog_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + CNT_W'(1);
                end
            end

            ST_FAULT: begin
                state_d = ST_FAULT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Downstream mux of the granted port; everything is quiet in IDLE and FAULT.
    always_comb begin
        bus_re     = 1'b0;
        bus_we     = 1'b0;
        bus_asize  = 2'd0;
        bus_addr   = '0;
        bus_wdata  = '0;
        prog_ready = 1'b0;
        mem_ready  = 1'b0;
        bus_fault  = 1'b0;

        case (state_q)
            ST_GNT_MEM: begin
                // read and write together is a write
                bus_re    = mem_re & ~mem_we;
                bus_we    = mem_we;
                bus_asize = mem_asize;
                bus_addr  = mem_addr;
                bus_wdata = mem_wdata;
                mem_ready = bus_ready;
            end
            ST_GNT_PROG: begin
                bus_re     = 1'b1;
                bus_asize  = WORD_SIZE;
                bus_addr   = prog_addr;
                prog_ready = bus_ready;
            end
            ST_FAULT: begin
                bus_fault = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_axo_bus_arbiter.sv
// Testbench for axo_bus_arbiter: directed cycle tables, hand-written watchdog
// and reset sequences, then random traffic checked against a reference model.
module tb_axo_bus_arbiter;

    localparam int unsigned XLEN = 32;
    localparam int unsigned TMO  = 4;

    logic            clk;
    logic            rst;
    logic            prog_re;
    logic [XLEN-1:0] prog_addr;
    logic            prog_ready;
    logic [XLEN-1:0] prog_data;
    logic            mem_re;
    logic            mem_we;
    logic [1:0]      mem_asize;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;
    logic            bus_re;
    logic            bus_we;
    logic [1:0]      bus_asize;
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic [XLEN-1:0] bus_rdata;
    logic            bus_ready;
    logic            bus_fault;

    axo_bus_arbiter #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_re    (prog_re),
        .prog_addr  (prog_addr),
        .prog_ready (prog_ready),
        .prog_data  (prog_data),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_asize  (mem_asize),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .bus_re     (bus_re),
        .bus_we     (bus_we),
        .bus_asize  (bus_asize),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ready  (bus_ready),
        .bus_fault  (bus_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        pr;
        logic [31:0] pa;
        logic        mre;
        logic        mwe;
        logic [1:0]  msz;
        logic [31:0] ma;
        logic [31:0] mwd;
        logic        brdy;
        logic [31:0] brd;
    } stim_t;

    typedef struct packed {
        logic        re;
        logic        we;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        prdy;
        logic        mrdy;
        logic        flt;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } row_t;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic stim_t mk_s(logic r, logic pr, logic [31:0] pa, logic mre, logic mwe,
                                   logic [1:0] msz, logic [31:0] ma, logic [31:0] mwd,
                                   logic brdy, logic [31:0] brd);
        stim_t s;
        s = '{r, pr, pa, mre, mwe, msz, ma, mwd, brdy, brd};
        return s;
    endfunction

    function automatic exp_t mk_e(logic re, logic we, logic [1:0] sz, logic [31:0] addr,
                                  logic [31:0] wd, logic prdy, logic mrdy, logic flt);
        exp_t e;
        e = '{re, we, sz, addr, wd, prdy, mrdy, flt};
        return e;
    endfunction

    task automatic apply(input stim_t s);
        rst       = s.rst;
        prog_re   = s.pr;
        prog_addr = s.pa;
        mem_re    = s.mre;
        mem_we    = s.mwe;
        mem_asize = s.msz;
        mem_addr  = s.ma;
        mem_wdata = s.mwd;
        bus_ready = s.brdy;
        bus_rdata = s.brd;
    endtask

    task automatic check(input string name, input exp_t e, input logic [31:0] rd);
        exp_t g;
        g = '{bus_re, bus_we, bus_asize, bus_addr, bus_wdata, prog_ready, mem_ready, bus_fault};
        n_cmp++;
        if (g !== e || prog_data !== rd || mem_rdata !== rd) begin
            n_bad++;
            $display("FAIL %s @%0t: got re=%0b we=%0b sz=%0d addr=%h wd=%h prdy=%0b mrdy=%0b flt=%0b pdata=%h mdata=%h | want re=%0b we=%0b sz=%0d addr=%h wd=%h prdy=%0b mrdy=%0b flt=%0b rdata=%h",
                     name, $time, g.re, g.we, g.sz, g.addr, g.wd, g.prdy, g.mrdy, g.flt,
                     prog_data, mem_rdata, e.re, e.we, e.sz, e.addr, e.wd, e.prdy, e.mrdy,
                     e.flt, rd);
        end
    endtask

    // One cycle: drive at the falling edge, compare shortly after.
    task automatic cyc(input string name, input stim_t s, input exp_t e);
        @(negedge clk);
        apply(s);
        #1;
        check(name, e, s.brd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        apply(mk_s(1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0, 0));
    endtask

    // Reference model: who owns the bus and how long it has waited.
    localparam int OWN_NONE = 0, OWN_DATA = 1, OWN_FETCH = 2, OWN_FAULT = 3;
    int m_owner;
    int m_last;     // OWN_NONE until a transfer completes, then the port served
    int m_stalls;

    function automatic exp_t model_out(input stim_t s);
        exp_t e;
        e = '0;
        if (m_owner == OWN_DATA) begin
            e.re   = s.mre & ~s.mwe;
            e.we   = s.mwe;
            e.sz   = s.msz;
            e.addr = s.ma;
            e.wd   = s.mwd;
            e.mrdy = s.brdy;
        end else if (m_owner == OWN_FETCH) begin
            e.re   = 1'b1;
            e.sz   = 2'd2;
            e.addr = s.pa;
            e.prdy = s.brdy;
        end else if (m_owner == OWN_FAULT) begin
            e.flt = 1'b1;
        end
        return e;
    endfunction

    task automatic model_step(input stim_t s);
        logic want_d, want_f;
        want_d = s.mre | s.mwe;
        want_f = s.pr;
        if (s.rst) begin
            m_owner = OWN_NONE; m_last = OWN_NONE; m_stalls = 0;
        end else if (m_owner == OWN_NONE) begin
            m_stalls = 0;
            if (want_d && want_f) m_owner = (m_last == OWN_DATA) ? OWN_FETCH : OWN_DATA;
            else if (want_d)      m_owner = OWN_DATA;
            else if (want_f)      m_owner = OWN_FETCH;
        end else if (m_owner != OWN_FAULT) begin
            if (s.brdy) begin
                m_last   = m_owner;
                m_stalls = 0;
                if (m_owner == OWN_DATA) m_owner = want_f ? OWN_FETCH : OWN_NONE;
                else                     m_owner = want_d ? OWN_DATA : OWN_NONE;
            end else if (m_stalls == int'(TMO)) begin
                m_owner = OWN_FAULT;
            end else if ((m_owner == OWN_DATA && !want_d) || (m_owner == OWN_FETCH && !want_f)) begin
                m_owner = OWN_NONE; m_stalls = 0;
            end else begin
                m_stalls++;
            end
        end
    endtask

    row_t  tbl[$];
    exp_t  z, flt_e, wr_e;
    stim_t s;

    initial begin
        z     = mk_e(0, 0, 2'd0, 0, 0, 0, 0, 0);
        flt_e = mk_e(0, 0, 2'd0, 0, 0, 0, 0, 1);

        // Contention right after reset: data first, then alternate without bubbles.
        tbl.push_back('{mk_s(0, 1, 32'h104, 1, 0, 2'd2, 32'h40, 0, 1, 32'h11111111), z});
        tbl.push_back('{mk_s(0, 1, 32'h104, 1, 0, 2'd2, 32'h40, 0, 1, 32'h22222222),
                        mk_e(1, 0, 2'd2, 32'h40, 0, 0, 1, 0)});
        tbl.push_back('{mk_s(0, 1, 32'h104, 1, 0, 2'd2, 32'h44, 0, 1, 32'h33333333),
                        mk_e(1, 0, 2'd2, 32'h104, 0, 1, 0, 0)});
        tbl.push_back('{mk_s(0, 1, 32'h108, 1, 0, 2'd2, 32'h44, 0, 1, 32'h44444444),
                        mk_e(1, 0, 2'd2, 32'h44, 0, 0, 1, 0)});
        tbl.push_back('{mk_s(0, 1, 32'h108, 0, 0, 2'd0, 0, 0, 1, 32'h55555555),
                        mk_e(1, 0, 2'd2, 32'h108, 0, 1, 0, 0)});
        tbl.push_back('{mk_s(0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 0), z});
        // Single fetch.
        tbl.push_back('{mk_s(0, 1, 32'h100, 0, 0, 2'd0, 0, 0, 1, 32'hDEADBEEF), z});
        tbl.push_back('{mk_s(0, 1, 32'h100, 0, 0, 2'd0, 0, 0, 1, 32'hDEADBEEF),
                        mk_e(1, 0, 2'd2, 32'h100, 0, 1, 0, 0)});
        tbl.push_back('{mk_s(0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 0), z});
        // Byte write with ready delayed three cycles.
        wr_e = mk_e(0, 1, 2'd0, 32'h203, 32'hAB, 0, 0, 0);
        tbl.push_back('{mk_s(0, 0, 0, 0, 1, 2'd0, 32'h203, 32'hAB, 0, 0), z});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{mk_s(0, 0, 0, 0, 1, 2'd0, 32'h203, 32'hAB, 0, 0), wr_e});
        wr_e.mrdy = 1'b1;
        tbl.push_back('{mk_s(0, 0, 0, 0, 1, 2'd0, 32'h203, 32'hAB, 1, 32'h0BADF00D), wr_e});
        tbl.push_back('{mk_s(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0), z});
        // Data request dropped while stalled: strobe falls at once, grant released next cycle.
        tbl.push_back('{mk_s(0, 0, 0, 1, 0, 2'd2, 32'h300, 0, 0, 0), z});
        tbl.push_back('{mk_s(0, 0, 0, 1, 0, 2'd2, 32'h300, 0, 0, 0),
                        mk_e(1, 0, 2'd2, 32'h300, 0, 0, 0, 0)});
        tbl.push_back('{mk_s(0, 0, 0, 0, 0, 2'd2, 32'h300, 0, 0, 0),
                        mk_e(0, 0, 2'd2, 32'h300, 0, 0, 0, 0)});
        tbl.push_back('{mk_s(0, 1, 32'h500, 0, 0, 2'd0, 0, 0, 1, 32'h5A5A5A5A), z});
        tbl.push_back('{mk_s(0, 1, 32'h500, 0, 0, 2'd0, 0, 0, 1, 32'h5A5A5A5A),
                        mk_e(1, 0, 2'd2, 32'h500, 0, 1, 0, 0)});
        tbl.push_back('{mk_s(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0), z});

        apply(mk_s(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
        do_reset();
        for (int i = 0; i < 10; i++)
            cyc("reset_idle", mk_s(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0), z);

        do_reset();
        for (int i = 0; i < tbl.size(); i++)
            cyc($sformatf("tbl%0d", i), tbl[i].s, tbl[i].e);

        // Watchdog: fetch stalled; fault from grant+5, requests ignored, reset clears it.
        do_reset();
        s = mk_s(0, 1, 32'h600, 0, 0, 2'd0, 0, 0, 0, 0);
        cyc("wd_req", s, z);
        for (int i = 0; i < 5; i++)
            cyc($sformatf("wd_stall%0d", i), s, mk_e(1, 0, 2'd2, 32'h600, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            cyc($sformatf("wd_fault%0d", i),
                mk_s(0, 1, 32'h600, 1, 0, 2'd2, 32'h700, 0, 1, 0), flt_e);
        cyc("wd_rst", mk_s(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0), flt_e);
        cyc("wd_clear", mk_s(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0), z);
        s = mk_s(0, 1, 32'h610, 0, 0, 2'd0, 0, 0, 1, 32'h12345678);
        cyc("wd_again_req", s, z);
        cyc("wd_again_gnt", s, mk_e(1, 0, 2'd2, 32'h610, 0, 1, 0, 0));
        cyc("wd_again_idle", mk_s(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0), z);

        // Ready arriving as the counter reaches its limit completes the transfer.
        s = mk_s(0, 1, 32'h620, 0, 0, 2'd0, 0, 0, 0, 0);
        cyc("edge_req", s, z);
        for (int i = 0; i < 4; i++)
            cyc($sformatf("edge_stall%0d", i), s, mk_e(1, 0, 2'd2, 32'h620, 0, 0, 0, 0));
        s.brdy = 1'b1;
        cyc("edge_done", s, mk_e(1, 0, 2'd2, 32'h620, 0, 1, 0, 0));
        cyc("edge_nofault", mk_s(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0), z);

        // Reset in the middle of a stalled write aborts it with no ready.
        do_reset();
        s = mk_s(0, 0, 0, 0, 1, 2'd2, 32'h800, 32'h55, 0, 0);
        wr_e = mk_e(0, 1, 2'd2, 32'h800, 32'h55, 0, 0, 0);
        cyc("mrst_req", s, z);
        cyc("mrst_gnt", s, wr_e);
        s.rst = 1'b1;
        cyc("mrst_edge", s, wr_e);
        s.rst = 1'b0;
        cyc("mrst_after", s, z);
        cyc("mrst_idle", mk_s(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0), z);

        // Random traffic with requesters that hold each transfer until its ready.
        begin
            logic        mp, m_wr, pp;
            logic [1:0]  m_sz;
            logic [31:0] m_a, m_wd, p_a;
            exp_t        e;
            do_reset();
            m_owner = OWN_NONE; m_last = OWN_NONE; m_stalls = 0;
            mp = 1'b0; pp = 1'b0; m_wr = 1'b0; m_sz = 2'd0;
            m_a = 0; m_wd = 0; p_a = 0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                if (!mp && $urandom_range(99) < 35) begin
                    mp   = 1'b1;
                    m_wr = 1'($urandom_range(1));
                    m_sz = 2'($urandom_range(2));
                    m_a  = $urandom;
                    m_wd = $urandom;
                end
                if (!pp && $urandom_range(99) < 35) begin
                    pp  = 1'b1;
                    p_a = $urandom & 32'hFFFF_FFFC;
                end
                s.rst  = (m_owner == OWN_FAULT) || ($urandom_range(199) == 0);
                s.pr   = pp;
                s.pa   = p_a;
                s.mre  = mp & ~m_wr;
                s.mwe  = mp & m_wr;
                s.msz  = m_sz;
                s.ma   = m_a;
                s.mwd  = m_wd;
                s.brdy = ($urandom_range(99) < 55);
                s.brd  = $urandom;
                apply(s);
                #1;
                e = model_out(s);
                check("random", e, s.brd);
                if (e.mrdy) mp = 1'b0;
                if (e.prdy) pp = 1'b0;
                model_step(s);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axo_bus_arbiter.md
# axo_bus_arbiter

Two-requester memory arbiter for the Axolotl³² core. It shares one downstream memory port between the instruction-fetch port (`prog_*`) and the load/store port (`mem_*`), so that a single-ported RAM can back both. It holds each grant until the transfer completes and alternates when both ports contend. A watchdog latches a sticky fault if the downstream port stalls for too long.

## Interface
Parameters:
- `XLEN`, 32, address/data width.
- `TIMEOUT`, 255, maximum consecutive not-ready cycles per transfer before fault; 0 disables the watchdog; legal range 0..65535.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `prog_re` in 1: fetch request; always a word read.
- `prog_addr` in XLEN: fetch address.
- `prog_ready` out 1: fetch completes this cycle.
- `prog_data` out XLEN: fetch data; valid when `prog_ready`.
- `mem_re` in 1: data read request.
- `mem_we` in 1: data write request.
- `mem_asize` in 2: access size, 2^n bytes.
- `mem_addr` in XLEN: data address.
- `mem_wdata` in XLEN: write data.
- `mem_rdata` out XLEN: read data; valid when `mem_ready`.
- `mem_ready` out 1: data access completes this cycle.
- `bus_re` out 1: downstream read strobe.
- `bus_we` out 1: downstream write strobe.
- `bus_asize` out 2: downstream access size.
- `bus_addr` out XLEN: downstream address.
- `bus_wdata` out XLEN: downstream write data.
- `bus_rdata` in XLEN: downstream read data.
- `bus_ready` in 1: downstream transfer completes this cycle.
- `bus_fault` out 1: sticky watchdog fault.

## Operation
- States: IDLE, GNT_MEM, GNT_PROG, FAULT. The state is registered; downstream outputs are a combinational mux of the granted port.
- "Data request" means `mem_re | mem_we`. `mem_re` and `mem_we` both high is treated as a write.
- IDLE:
  - Data request only: go to GNT_MEM.
  - Fetch request only: go to GNT_PROG.
  - Both: go to the port not served last. `last_prog` register, reset 0, so data wins the first tie.
- GNT_MEM:
  - `bus_re`, `bus_we`, `bus_asize`, `bus_addr`, `bus_wdata` are copied from the `mem_*` inputs.
  - `mem_ready` = `bus_ready`.
- GNT_PROG:
  - `bus_re` = 1, `bus_we` = 0, `bus_asize` = 2, `bus_addr` = `prog_addr`, `bus_wdata` = 0.
  - `prog_ready` = `bus_ready`.
- `prog_data` and `mem_rdata` are both wired directly to `bus_rdata`.
- Completion occurs on a cycle in a grant state with `bus_ready` = 1.
  - `last_prog` is updated to the port just served.
  - During arbitration in the completion cycle, the completing port counts as not requesting.
  - If the other port is requesting, the next state is its grant state (no bubble). Otherwise the next state is IDLE.
  - As a result, back-to-back requests from the same port always see one IDLE cycle between them.
- Requesters must hold their request and all attributes stable until their ready. If the granted port drops its request before `bus_ready`, the grant is released the next cycle (back to IDLE). Strobes follow the request combinationally, so they fall in that same cycle.
- Watchdog:
  - 16-bit counter, cleared on entry to any grant state and on completion.
  - Increments on each grant-state cycle with `bus_ready` = 0.
  - When the counter reaches `TIMEOUT` (and `TIMEOUT` ≠ 0), the next state is FAULT.
- FAULT:
  - All strobes 0, both readies 0, `bus_fault` = 1.
  - The arbiter stays in FAULT until `rst`.
- Non-granted port ready is always 0. In IDLE and FAULT, all `bus_*` outputs are 0.

## Timing
- Reset (cycle after `rst` sampled high): state IDLE, `last_prog` 0, counter 0, `bus_fault` 0.
- After reset, all `bus_*` outputs, `prog_ready` and `mem_ready` read 0.
- `rst` asserted mid-transfer aborts it. Strobes go to 0 the cycle after the `rst` edge, and no ready is issued.
- Arbitration latency: request first seen in IDLE at cycle n; grant and strobes at cycle n+1. The earliest completion is cycle n+1 if `bus_ready` is already high.
- Ready is combinational from `bus_ready`; there is no added latency on completion.
- Fault timing with `TIMEOUT` = T: grant at cycle g, `bus_ready` held low. The counter reaches T after T stalled cycles, and FAULT is entered at edge g+T+1.
- A `bus_ready` arriving in the same cycle the counter reaches T takes precedence as a completion; no fault.

## Test plan
- Reset then idle: `rst` 1 cycle, no requests → all `bus_*` 0, both readies 0, `bus_fault` 0 for 10 cycles.
- Single fetch: `prog_re`=1, `prog_addr`=0x100, `bus_ready` held 1 → `bus_re`=1, `bus_addr`=0x100, `bus_asize`=2 one cycle later; `prog_ready`=1 with `prog_data`=`bus_rdata`=0xDEADBEEF.
- Contention: both ports request continuously with `bus_ready`=1 → grants alternate MEM, PROG, MEM, PROG; no port waits more than one transfer.
- Write pass-through: `mem_we`=1, `mem_asize`=0, `mem_addr`=0x203, `mem_wdata`=0xAB → `bus_we`=1 with identical attributes; `mem_ready` follows a `bus_ready` delayed 3 cycles.
- Watchdog: `TIMEOUT`=4, fetch granted, `bus_ready` held 0 → `bus_fault`=1 and strobes 0 from grant+5 onward; a further request is ignored; `rst` clears the fault.
- Mid-transfer reset: `rst` during a stalled data write → `bus_we`=0 next cycle, `mem_ready` never asserted.
